// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the byte-serial RAM arbiter: FSM state and owner
// encodings, mem_len size codes, bus types and the size-code decoder.
package mem_arbiter_pkg;

    localparam logic Enable = 1'b1;

    typedef logic [7:0]  RamDataBus;
    typedef logic [31:0] InstAddrBus;

    typedef enum logic [1:0] {
        ArbIdle,
        ArbRd,
        ArbWr,
        ArbDone
    } arb_state_e;

    typedef enum logic {
        OwnIf,
        OwnMem
    } arb_owner_e;

    localparam logic [1:0] Len1 = 2'b00;
    localparam logic [1:0] Len2 = 2'b01;
    localparam logic [1:0] Len4 = 2'b11;

    // Number of RAM byte cycles for a size code; the unused code 10 is a word.
    function automatic logic [2:0] len_bytes(input logic [1:0] len);
        case (len)
            Len1:    return 3'd1;
            Len2:    return 3'd2;
            Len4:    return 3'd4;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_arbiter_stats.sv
// Grant and conflict counters for the RAM arbiter, all wrapping modulo 2^32.
// Only instantiated when MEMARB_STATS_EN is defined.
module mem_arbiter_stats (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_grant_i,
    input  logic        mem_grant_i,
    input  logic        conflict_i,
    output logic [31:0] stat_if_grants_o,
    output logic [31:0] stat_mem_grants_o,
    output logic [31:0] stat_conflicts_o
);

    logic [31:0] if_grants_q, mem_grants_q, conflicts_q;

    // Count accepted requests per requester and IDLE cycles with both requesting.
    always_ff @(posedge clk) begin
        if (rst) begin
            if_grants_q  <= '0;
            mem_grants_q <= '0;
            conflicts_q  <= '0;
        end else begin
            if (if_grant_i)  if_grants_q  <= if_grants_q + 32'd1;
            if (mem_grant_i) mem_grants_q <= mem_grants_q + 32'd1;
            if (conflict_i)  conflicts_q  <= conflicts_q + 32'd1;
        end
    end

    assign stat_if_grants_o  = if_grants_q;
    assign stat_mem_grants_o = mem_grants_q;
    assign stat_conflicts_o  = conflicts_q;

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the byte-wide RAM port between IF and MEM, serialising
// 1/2/4-byte accesses little-endian with one-cycle done pulses. MEM has fixed
// priority. Define MEMARB_STATS_EN to add grant/conflict counter outputs.
module mem_arbiter
    import mem_arbiter_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_done,
    output logic [31:0] if_data,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [1:0]  mem_len,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic        mem_done,
    output logic [31:0] mem_rdata,
    output logic [31:0] ram_a,
    output logic        ram_wr,
    output logic [7:0]  ram_dout,
    input  logic [7:0]  ram_din
`ifdef MEMARB_STATS_EN
    ,
    output logic [31:0] stat_if_grants,
    output logic [31:0] stat_mem_grants,
    output logic [31:0] stat_conflicts
`endif
);

    arb_state_e  state_q;
    arb_owner_e  owner_q;
    logic [2:0]  cnt_q;
    logic [2:0]  n_q;
    InstAddrBus  base_q;
    logic [31:0] wdata_q;
    logic [31:0] rd_buf_q;
    logic [31:0] if_data_q;
    logic [31:0] mem_rdata_q;
    logic        if_done_q;
    logic        mem_done_q;

    logic [1:0]  rd_idx_d;
    logic [31:0] rd_word_d;
    RamDataBus   wr_byte_d;

    // Read buffer with the byte arriving this cycle merged in; ram_din belongs
    // to the address driven one cycle earlier, hence cnt - 1.
    always_comb begin
        rd_idx_d  = 2'(cnt_q - 3'd1);
        rd_word_d = rd_buf_q;
        rd_word_d[{rd_idx_d, 3'b000} +: 8] = ram_din;
    end

    // RAM pins depend only on state and counter, never on the request inputs.
    always_comb begin
        ram_a     = '0;
        ram_wr    = 1'b0;
        wr_byte_d = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
        ram_dout  = '0;
        if (state_q == ArbRd || state_q == ArbWr) begin
            ram_a = base_q + {29'd0, cnt_q};
        end
        if (state_q == ArbWr) begin
            ram_wr   = Enable;
            ram_dout = wr_byte_d;
        end
    end

    // Arbitration FSM with registered done pulses and read data.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ArbIdle;
            owner_q     <= OwnIf;
            cnt_q       <= '0;
            n_q         <= '0;
            base_q      <= '0;
            wdata_q     <= '0;
            rd_buf_q    <= '0;
            if_data_q   <= '0;
            mem_rdata_q <= '0;
            if_done_q   <= 1'b0;
            mem_done_q  <= 1'b0;
        end else begin
            if_done_q  <= 1'b0;
            mem_done_q <= 1'b0;
            case (state_q)
                ArbIdle: begin
                    cnt_q    <= '0;
                    rd_buf_q <= '0;
                    if (mem_req == Enable) begin
                        owner_q <= OwnMem;
                        base_q  <= mem_addr;
                        n_q     <= len_bytes(mem_len);
                        wdata_q <= mem_wdata;
                        state_q <= mem_we ? ArbWr : ArbRd;
                    end else if (if_req == Enable && !flush) begin
                        owner_q <= OwnIf;
                        base_q  <= if_addr;
                        n_q     <= 3'd4;
                        state_q <= ArbRd;
                    end
                end
                ArbRd: begin
                    if (owner_q == OwnIf && flush) begin
                        state_q <= ArbIdle;
                    end else begin
                        cnt_q <= cnt_q + 3'd1;
                        if (cnt_q != '0) rd_buf_q <= rd_word_d;
                        if (cnt_q == n_q) begin
                            state_q <= ArbDone;
                            if (owner_q == OwnIf) begin
                                if_data_q <= rd_word_d;
                                if_done_q <= 1'b1;
                            end else begin
                                mem_rdata_q <= rd_word_d;
                                mem_done_q  <= 1'b1;
                            end
                        end
                    end
                end
                ArbWr: begin
                    cnt_q <= cnt_q + 3'd1;
                    if (cnt_q == 3'(n_q - 3'd1)) begin
                        state_q    <= ArbDone;
                        mem_done_q <= 1'b1;
                    end
                end
                ArbDone: state_q <= ArbIdle;
                default: state_q <= ArbIdle;
            endcase
        end
    end

    assign if_done   = if_done_q;
    assign if_data   = if_data_q;
    assign mem_done  = mem_done_q;
    assign mem_rdata = mem_rdata_q;

`ifdef MEMARB_STATS_EN
    logic if_grant, mem_grant, conflict;

    // Acceptance and conflict strobes mirror the IDLE arbitration decision.
    always_comb begin
        mem_grant = (state_q == ArbIdle) && mem_req;
        if_grant  = (state_q == ArbIdle) && !mem_req && if_req && !flush;
        conflict  = (state_q == ArbIdle) && mem_req && if_req;
    end

    mem_arbiter_stats u_stats (
        .clk               (clk),
        .rst               (rst),
        .if_grant_i        (if_grant),
        .mem_grant_i       (mem_grant),
        .conflict_i        (conflict),
        .stat_if_grants_o  (stat_if_grants),
        .stat_mem_grants_o (stat_mem_grants),
        .stat_conflicts_o  (stat_conflicts)
    );
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table plus multi-cycle corner
// sequences, with a done-pulse scoreboard and a byte-wide RAM model.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst, flush;
    logic        if_req, if_done;
    logic [31:0] if_addr, if_data;
    logic        mem_req, mem_we, mem_done;
    logic [1:0]  mem_len;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [31:0] ram_a;
    logic        ram_wr;
    logic [7:0]  ram_dout;
    logic [7:0]  ram_din = 8'h00;
`ifdef MEMARB_STATS_EN
    logic [31:0] stat_if_grants, stat_mem_grants, stat_conflicts;
`endif

    mem_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_done   (if_done),
        .if_data   (if_data),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_len   (mem_len),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_done  (mem_done),
        .mem_rdata (mem_rdata),
        .ram_a     (ram_a),
        .ram_wr    (ram_wr),
        .ram_dout  (ram_dout),
        .ram_din   (ram_din)
`ifdef MEMARB_STATS_EN
        ,
        .stat_if_grants  (stat_if_grants),
        .stat_mem_grants (stat_mem_grants),
        .stat_conflicts  (stat_conflicts)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // RAM model: byte addressed, read data one cycle after the address.
    logic [7:0] ram [logic [31:0]];

    function automatic logic [7:0] rd_byte(input logic [31:0] a);
        if (ram.exists(a)) return ram[a];
        return 8'h00;
    endfunction

    always @(posedge clk) ram_din <= rd_byte(ram_a);

    typedef struct {
        int          cyc;
        logic [31:0] data;
        bit          chk;
        string       nm;
    } exp_t;

    typedef struct {
        int          cyc;
        logic [31:0] a;
        logic [7:0]  d;
    } wr_t;

    exp_t if_q[$];
    exp_t mem_q[$];
    wr_t  wlog[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Scoreboard monitor: done pulses against queued expectations, RAM writes.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (if_done) begin
                if (if_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL if_done_unexpected: got pulse at cycle %0d want none", cyc);
                end else begin
                    e = if_q.pop_front();
                    check({e.nm, "_ifdone_cyc"}, cyc, e.cyc);
                    if (e.chk) check({e.nm, "_if_data"}, if_data, e.data);
                end
            end
            if (mem_done) begin
                if (mem_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL mem_done_unexpected: got pulse at cycle %0d want none", cyc);
                end else begin
                    e = mem_q.pop_front();
                    check({e.nm, "_memdone_cyc"}, cyc, e.cyc);
                    if (e.chk) check({e.nm, "_mem_rdata"}, mem_rdata, e.data);
                end
            end
            if (ram_wr) begin
                ram[ram_a] = ram_dout;
                wlog.push_back('{cyc, ram_a, ram_dout});
            end
        end
    end

    typedef struct {
        bit          is_mem;
        bit          we;
        logic [1:0]  len;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rbytes;
        logic [31:0] exp_data;
        int          exp_done;
    } vec_t;

    vec_t vecs[9];

    function automatic int nbytes(input vec_t v);
        if (!v.is_mem) return 4;
        if (v.len == 2'b00) return 1;
        if (v.len == 2'b01) return 2;
        return 4;
    endfunction

    task automatic run_vec(input int idx, input vec_t v);
        int          n, t0, rel;
        bit          done;
        logic [31:0] a_seen[4];
        string       nm;
        wr_t         w;
        nm = $sformatf("v%0d", idx);
        n  = nbytes(v);
        for (int k = 0; k < 4; k++) a_seen[k] = '0;
        if (!v.we) begin
            for (int k = 0; k < n; k++) ram[v.addr + 32'(k)] = v.rbytes[8*k +: 8];
        end
        wlog.delete();
        @(posedge clk); #1;
        if (v.is_mem) begin
            mem_req = 1'b1; mem_we = v.we; mem_len = v.len;
            mem_addr = v.addr; mem_wdata = v.wdata;
        end else begin
            if_req = 1'b1; if_addr = v.addr;
        end
        t0 = cyc;
        if (v.is_mem) mem_q.push_back('{t0 + v.exp_done, v.exp_data, !v.we, nm});
        else          if_q.push_back('{t0 + v.exp_done, v.exp_data, 1'b1, nm});
        done = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            rel = cyc - t0;
            if (rel >= 1 && rel <= n) a_seen[rel-1] = ram_a;
            if ((v.is_mem && mem_done) || (!v.is_mem && if_done)) done = 1'b1;
        end
        check({nm, "_completed"}, {31'd0, done}, 32'd1);
        @(posedge clk); #1;
        mem_req = 1'b0; if_req = 1'b0;
        if (v.we) begin
            check({nm, "_wr_count"}, wlog.size(), n);
            for (int k = 0; k < n && k < wlog.size(); k++) begin
                w = wlog[k];
                check($sformatf("%s_wr%0d_cyc", nm, k), w.cyc - t0, k + 1);
                check($sformatf("%s_wr%0d_addr", nm, k), w.a, v.addr + 32'(k));
                check($sformatf("%s_wr%0d_byte", nm, k), {24'd0, w.d}, {24'd0, v.wdata[8*k +: 8]});
            end
        end else begin
            check({nm, "_no_writes"}, wlog.size(), 0);
            for (int k = 0; k < n; k++)
                check($sformatf("%s_rd_addr%0d", nm, k), a_seen[k], v.addr + 32'(k));
        end
    endtask

    initial begin
        int  t0, rel, early, nd, wr_late;
        bit  if_fin, mem_fin;
`ifdef MEMARB_STATS_EN
        logic [31:0] conf0, ifg0, memg0;
`endif
        #200000;
        $display("FAIL watchdog: got no finish by time limit want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  t0, rel, early, nd, wr_late;
        bit  if_fin, mem_fin;
`ifdef MEMARB_STATS_EN
        logic [31:0] conf0, ifg0, memg0;
`endif
        //              mem we len    addr          wdata         rbytes        exp           done
        vecs[0] = '{1'b0, 1'b0, 2'b00, 32'h0000_1000, 32'h0,        32'h0000_0013, 32'h0000_0013, 6};
        vecs[1] = '{1'b1, 1'b1, 2'b11, 32'h0000_3000, 32'hDEAD_BEEF, 32'h0,        32'h0,        5};
        vecs[2] = '{1'b1, 1'b0, 2'b10, 32'h0000_4000, 32'h0,        32'h4433_2211, 32'h4433_2211, 6};
        vecs[3] = '{1'b1, 1'b0, 2'b00, 32'h0000_2000, 32'h0,        32'h0000_00A5, 32'h0000_00A5, 3};
        vecs[4] = '{1'b1, 1'b0, 2'b01, 32'h0000_0FFF, 32'h0,        32'h0000_1234, 32'h0000_1234, 4};
        vecs[5] = '{1'b1, 1'b1, 2'b00, 32'h0000_5003, 32'h1234_56AB, 32'h0,        32'h0,        2};
        vecs[6] = '{1'b1, 1'b1, 2'b01, 32'hFFFF_FFFF, 32'h0000_CAFE, 32'h0,        32'h0,        3};
        vecs[7] = '{1'b1, 1'b0, 2'b11, 32'hFFFF_FFFE, 32'h0,        32'h89AB_CDEF, 32'h89AB_CDEF, 6};
        vecs[8] = '{1'b0, 1'b0, 2'b00, 32'h0000_1002, 32'h0,        32'h0403_0201, 32'h0403_0201, 6};

        rst = 1'b1; flush = 1'b0;
        if_req = 1'b0; if_addr = '0;
        mem_req = 1'b0; mem_we = 1'b0; mem_len = '0; mem_addr = '0; mem_wdata = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_ram_a",     ram_a, 32'h0);
        check("rst_ram_wr",    {31'd0, ram_wr}, 32'h0);
        check("rst_ram_dout",  {24'd0, ram_dout}, 32'h0);
        check("rst_if_done",   {31'd0, if_done}, 32'h0);
        check("rst_mem_done",  {31'd0, mem_done}, 32'h0);
        check("rst_if_data",   if_data, 32'h0);
        check("rst_mem_rdata", mem_rdata, 32'h0);

        for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

        // Simultaneous MEM load and IF fetch: MEM first, IF slips behind DONE.
        ram[32'h2000] = 8'h5A;
        ram[32'h1000] = 8'h13; ram[32'h1001] = 8'h00;
        ram[32'h1002] = 8'h00; ram[32'h1003] = 8'h00;
`ifdef MEMARB_STATS_EN
        conf0 = stat_conflicts; ifg0 = stat_if_grants; memg0 = stat_mem_grants;
`endif
        @(posedge clk); #1;
        mem_req = 1'b1; mem_we = 1'b0; mem_len = 2'b00; mem_addr = 32'h2000;
        if_req = 1'b1; if_addr = 32'h1000;
        t0 = cyc;
        mem_q.push_back('{t0 + 3, 32'h0000_005A, 1'b1, "arb_mem"});
        if_q.push_back('{t0 + 10, 32'h0000_0013, 1'b1, "arb_if"});
        if_fin = 1'b0; mem_fin = 1'b0;
        for (int c = 0; c < 40 && !if_fin; c++) begin
            @(negedge clk);
            rel = cyc - t0;
            if (mem_done) mem_fin = 1'b1;
            if (if_done) if_fin = 1'b1;
            if (rel == 1) check("arb_mem_addr", ram_a, 32'h2000);
            if (rel == 4) check("arb_idle_gap", ram_a, 32'h0);
            if (rel == 5) check("arb_if_first_addr", ram_a, 32'h1000);
            @(posedge clk); #1;
            if (mem_fin) mem_req = 1'b0;
        end
        if_req = 1'b0;
        check("arb_if_completed", {31'd0, if_fin}, 32'd1);
`ifdef MEMARB_STATS_EN
        check("stat_conflicts_delta", stat_conflicts - conf0, 32'd1);
        check("stat_if_grants_delta", stat_if_grants - ifg0, 32'd1);
        check("stat_mem_grants_delta", stat_mem_grants - memg0, 32'd1);
`endif

        // Flush in cycle 3 of a fetch aborts it; a new fetch in cycle 4 completes.
        for (int k = 0; k < 4; k++) ram[32'h6000 + 32'(k)] = 8'hFF;
        ram[32'h7000] = 8'h93; ram[32'h7001] = 8'h00;
        ram[32'h7002] = 8'h50; ram[32'h7003] = 8'h00;
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = 32'h6000;
        t0 = cyc;
        if_q.push_back('{t0 + 10, 32'h0050_0093, 1'b1, "flush_refetch"});
        if_fin = 1'b0; early = 0;
        for (int c = 0; c < 40 && !if_fin; c++) begin
            @(negedge clk);
            rel = cyc - t0;
            if (if_done) begin
                if (rel < 10) early++;
                else if_fin = 1'b1;
            end
            if (rel == 4) check("flush_idle_ram_a", ram_a, 32'h0);
            if (rel == 5) check("flush_refetch_addr", ram_a, 32'h7000);
            @(posedge clk); #1;
            rel = cyc - t0;
            if (rel == 3) flush = 1'b1;
            if (rel == 4) begin flush = 1'b0; if_addr = 32'h7000; end
        end
        if_req = 1'b0;
        check("flush_no_early_done", early, 0);
        check("flush_refetch_completed", {31'd0, if_fin}, 32'd1);

        // Reset in cycle 2 of a word store: RAM strobe gone from cycle 3, no done.
        wlog.delete();
        @(posedge clk); #1;
        mem_req = 1'b1; mem_we = 1'b1; mem_len = 2'b11;
        mem_addr = 32'h8000; mem_wdata = 32'h0102_0304;
        t0 = cyc; nd = 0; wr_late = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            rel = cyc - t0;
            if (mem_done) nd++;
            if (rel >= 3 && ram_wr) wr_late++;
            if (rel == 3) check("rstwr_idle_ram_a", ram_a, 32'h0);
            @(posedge clk); #1;
            rel = cyc - t0;
            if (rel == 2) begin rst = 1'b1; mem_req = 1'b0; end
            if (rel == 3) rst = 1'b0;
        end
        check("rstwr_no_done", nd, 0);
        check("rstwr_no_late_wr", wr_late, 0);
        check("rstwr_partial_writes", wlog.size(), 2);
        check("rstwr_rdata_cleared", mem_rdata, 32'h0);

        check("sb_if_empty", if_q.size(), 0);
        check("sb_mem_empty", mem_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
